// File: rtl/conv_enc_pkg.sv
// conv_enc_pkg: shared types and helpers for the convolutional encoder.
// FSM state constants, default K=3 rate-1/2 generators, counter widths.
package conv_enc_pkg;

  typedef logic [0:0] conv_state_t;

  localparam conv_state_t S_RUN  = 1'b0;
  localparam conv_state_t S_TAIL = 1'b1;

  // generator 1 = 101, generator 0 = 111
  localparam logic [5:0] CONV_G_K3_R12 = {3'b101, 3'b111};

  // counter width for n distinct values, at least one bit
  function automatic int conv_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_enc_serializer.sv
// conv_enc_serializer: one-codeword buffer, serial out handshake, puncturing.
// Ports: clk, reset (async low), load/load_cw/load_end, out_*, free.
// Macro CONV_ENC_PUNCT_EN adds PUNCT_P/PUNCT_MASK and the load_tail port.
module conv_enc_serializer
  import conv_enc_pkg::*;
#(
  parameter int N = 2
`ifdef CONV_ENC_PUNCT_EN
  ,
  parameter int PUNCT_P = 2,
  parameter logic [N*PUNCT_P-1:0] PUNCT_MASK = '1
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_cw,
`ifdef CONV_ENC_PUNCT_EN
  input  logic         load_tail,
`endif
  input  logic         load_end,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_bit,
  output logic         out_last,
  output logic         free
);

  localparam int IW = conv_cnt_w(N);

  logic [N-1:0]  cw;
  logic          full;
  logic          fin;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] idx_first;
  logic          last_kept;
  logic [N-1:0]  keep;
  logic [N-1:0]  keep_new;

`ifdef CONV_ENC_PUNCT_EN
  localparam int PW = conv_cnt_w(PUNCT_P);

  logic [PW-1:0] phase;

  for (genvar j = 0; j < PUNCT_P; j++) begin : g_chk
    if (PUNCT_MASK[j*N +: N] == '0) begin : g_bad
      $error("conv_enc_serializer: mask column %0d keeps no bits", j);
    end
  end

  // tail codewords are always sent whole
  assign keep_new = load_tail ? '1
                  : PUNCT_MASK[int'(phase)*N +: N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      keep  <= '1;
      phase <= '0;
    end else if (load) begin
      keep <= keep_new;
      if (load_tail)
        phase <= '0;
      else if (phase == PW'(PUNCT_P - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end
`else
  assign keep_new = '1;
  assign keep     = '1;
`endif

  // next kept bit above idx, and first kept bit of a new codeword
  always_comb begin
    last_kept = 1'b1;
    idx_nxt   = idx;
    idx_first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i > int'(idx) && keep[i]) begin
        last_kept = 1'b0;
        idx_nxt   = IW'(i);
      end
      if (keep_new[i])
        idx_first = IW'(i);
    end
  end

  assign out_valid = full;
  assign out_bit   = cw[idx];
  assign out_last  = full & fin & last_kept;
  assign free      = !full | (out_ready & last_kept);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cw   <= '0;
      full <= 1'b0;
      idx  <= '0;
      fin  <= 1'b0;
    end else if (load) begin
      cw   <= load_cw;
      full <= 1'b1;
      idx  <= idx_first;
      fin  <= load_end;
    end else if (full && out_ready) begin
      if (last_kept)
        full <= 1'b0;
      else
        idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/N, constraint-K convolutional encoder, zero-tail flush.
// Ports: clk, reset (async low), in_valid/ready/bit/last, out_valid/ready/bit/last.
// Macro CONV_ENC_PUNCT_EN enables puncturing of data codewords.
module conv_encoder
  import conv_enc_pkg::*;
#(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = CONV_G_K3_R12,
  parameter int PUNCT_P = 2,
  parameter logic [N*PUNCT_P-1:0] PUNCT_MASK = 4'b0111
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
);

  localparam int TW = conv_cnt_w(K - 1);

  if (K < 2 || N < 2 || PUNCT_P < 1 || PUNCT_MASK == '0) begin : g_bad
    $error("conv_encoder: illegal parameters");
  end

  conv_state_t   state;
  logic [K-2:0]  sr;
  logic [TW-1:0] tcnt;
  logic          free;
  logic          tail;
  logic          acc;
  logic          gen;
  logic          d;
  logic          t_end;
  logic [K-1:0]  win;
  logic [N-1:0]  cw_new;

  assign tail     = (state == S_TAIL);
  assign in_ready = reset & !tail & free;
  assign acc      = in_valid & in_ready;
  assign gen      = acc | (tail & free);
  assign d        = !tail & in_bit;
  assign t_end    = tail & (tcnt == TW'(K - 2));
  assign win      = {d, sr};

  always_comb begin
    cw_new = '0;
    for (int i = 0; i < N; i++)
      cw_new[i] = ^(G[i*K +: K] & win);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
      sr    <= '0;
      tcnt  <= '0;
    end else if (gen) begin
      sr <= win[K-1:1];
      if (tail) begin
        tcnt  <= t_end ? '0 : tcnt + 1'b1;
        state <= t_end ? S_RUN : S_TAIL;
      end else if (in_last) begin
        state <= S_TAIL;
        tcnt  <= '0;
      end
    end
  end

  conv_enc_serializer #(
    .N(N)
`ifdef CONV_ENC_PUNCT_EN
    ,
    .PUNCT_P(PUNCT_P),
    .PUNCT_MASK(PUNCT_MASK)
`endif
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (gen),
    .load_cw  (cw_new),
`ifdef CONV_ENC_PUNCT_EN
    .load_tail(tail),
`endif
    .load_end (t_end),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .out_last (out_last),
    .free     (free)
  );

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed vector table for conv_encoder (K=3, N=2).
// Covers streams, stalls, tail gating, back-to-back frames, async reset abort.
module tb_conv_encoder;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic out_bit;
  logic out_last;

  conv_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bit  (out_bit),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    string din;
    string dlast;
    string exp;
    string exp_last;
    bit    toggle;
    bit    mid;
    int    ncyc;
  } vec_t;

  vec_t  vecs[$];
  int    checks = 0;
  int    failures = 0;
  string got_s;
  string got_l;

  function automatic vec_t mk(input string name, input string din,
                              input string dlast, input string exp,
                              input string exp_last, input bit toggle,
                              input bit mid, input int ncyc);
    vec_t v;
    v.name = name;
    v.din = din;
    v.dlast = dlast;
    v.exp = exp;
    v.exp_last = exp_last;
    v.toggle = toggle;
    v.mid = mid;
    v.ncyc = ncyc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%s exp=%s", nm, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input int stop_at);
    int   p;
    int   cyc;
    int   nexp;
    bit   pend;
    bit   stall;
    bit   vt;
    bit   vm;
    logic sb;
    logic sl;
    p = 0;
    cyc = 0;
    pend = 0;
    stall = 0;
    vt = 0;
    vm = 0;
    sb = 0;
    sl = 0;
    got_s = "";
    got_l = "";
    nexp = (stop_at > 0) ? stop_at : v.exp.len();
    while (got_s.len() < nexp && cyc < 300) begin
      @(negedge clk);
      in_valid = (p < v.din.len());
      in_bit = in_valid && (v.din[p] == "1");
      in_last = in_valid && (v.dlast[p] == "1");
      out_ready = v.toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (stall)
        chk({v.name, " stall_hold"}, {29'd0, out_valid, out_bit, out_last},
            {29'd0, 1'b1, sb, sl});
      stall = out_valid && !out_ready;
      sb = out_bit;
      sl = out_last;
      if (pend && in_ready && !(out_valid && out_ready && out_last))
        vt = 1;
      if (in_ready && out_valid && !(out_ready && (got_s.len() % 2 == 1)))
        vm = 1;
      if (out_valid && out_ready) begin
        if (out_bit) got_s = {got_s, "1"};
        else got_s = {got_s, "0"};
        if (out_last) begin
          got_l = {got_l, "1"};
          pend = 0;
        end else begin
          got_l = {got_l, "0"};
        end
      end
      if (in_valid && in_ready) begin
        if (in_last) pend = 1;
        p++;
      end
      cyc++;
      @(posedge clk);
    end
    if (got_s.len() < nexp) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got %0d of %0d bits", v.name,
               got_s.len(), nexp);
    end
    if (stop_at == 0) begin
      chk_s({v.name, " stream"}, got_s, v.exp);
      chk_s({v.name, " out_last"}, got_l, v.exp_last);
      chk({v.name, " tail_in_ready"}, {31'd0, vt}, 0);
      if (v.mid)
        chk({v.name, " mid_cw_in_ready"}, {31'd0, vm}, 0);
      if (v.ncyc > 0)
        chk({v.name, " cycles"}, cyc, v.ncyc);
      @(negedge clk);
      #1;
      chk({v.name, " idle"}, {31'd0, out_valid}, 0);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;

`ifdef CONV_ENC_PUNCT_EN
    vecs.push_back(mk("punct", "1011", "0001", "1110000111",
                      "0000000001", 1'b0, 1'b0, 11));
`else
    vecs.push_back(mk("frame", "1011", "0001", "111000010111",
                      "000000000001", 1'b0, 1'b1, 13));
    vecs.push_back(mk("stall", "1011", "0001", "111000010111",
                      "000000000001", 1'b1, 1'b1, 0));
    vecs.push_back(mk("single", "1", "1", "111011",
                      "000001", 1'b0, 1'b1, 7));
    vecs.push_back(mk("b2b", "10111", "00011", "111000010111111011",
                      "000000000001000001", 1'b0, 1'b1, 19));
`endif

    #2;
    chk("rst out_valid", {31'd0, out_valid}, 0);
    chk("rst out_bit", {31'd0, out_bit}, 0);
    chk("rst out_last", {31'd0, out_last}, 0);
    chk("rst in_ready", {31'd0, in_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel in_ready", {31'd0, in_ready}, 1);
    chk("rel out_valid", {31'd0, out_valid}, 0);

    foreach (vecs[i]) run(vecs[i], 0);

    v = vecs[0];
    v.name = "abort";
    run(v, 5);
    #1;
    chk("abort pre out_valid", {31'd0, out_valid}, 1);
    reset = 1'b0;
    #1;
    chk("abort out_valid", {31'd0, out_valid}, 0);
    chk("abort out_last", {31'd0, out_last}, 0);
    chk("abort in_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    v.name = "after_reset";
    run(v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
